// File: rtl/fp32_add_sub.sv
// -----------------------------------------------------------------------------
// fp32_add_sub
//
// Registered IEEE-754 binary32 adder/subtractor with round-to-nearest-even.
// The block handles normal, subnormal, zero, infinity and NaN operands. The
// datapath from the operand pins to the result register is purely
// combinational, so an operation has a latency of one cycle. A new operation
// can be accepted on every cycle.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset (clears Result and out_valid)
//   in_valid   : NumberA, NumberB and A_S are sampled while this is high
//   NumberA    : operand A, binary32
//   NumberB    : operand B, binary32
//   A_S        : 0 = A + B, 1 = A - B
//   Result     : registered binary32 result
//   out_valid  : high for one cycle when Result holds a freshly computed value
// -----------------------------------------------------------------------------
module fp32_add_sub (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] NumberA,
    input  logic [31:0] NumberB,
    input  logic        A_S,
    output logic [31:0] Result,
    output logic        out_valid
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Leading-zero count of a 27-bit working significand. Bit 26 is the hidden
    // bit position, so a value with bit 26 set returns 0; all-zero returns 27.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) begin
                n = 5'(26 - i);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // ---------------------------------------------------------------------
    // Unpacking
    // ---------------------------------------------------------------------
    logic        sa_s;
    logic        sb_s;
    logic [7:0]  ea_s;
    logic [7:0]  eb_s;
    logic [22:0] fa_s;
    logic [22:0] fb_s;
    logic [7:0]  ea_eff_s;
    logic [7:0]  eb_eff_s;
    logic [23:0] ma_s;
    logic [23:0] mb_s;
    logic        a_nan_s;
    logic        b_nan_s;
    logic        a_inf_s;
    logic        b_inf_s;

    assign sa_s = NumberA[31];
    // The subtract request simply flips B's sign; from here on every
    // operation is an addition of two signed magnitudes.
    assign sb_s = NumberB[31] ^ A_S;
    assign ea_s = NumberA[30:23];
    assign eb_s = NumberB[30:23];
    assign fa_s = NumberA[22:0];
    assign fb_s = NumberB[22:0];

    // Subnormals (exp field 0) behave as exponent 1 without a hidden bit.
    assign ea_eff_s = (ea_s == 8'd0) ? 8'd1 : ea_s;
    assign eb_eff_s = (eb_s == 8'd0) ? 8'd1 : eb_s;
    assign ma_s     = {(ea_s != 8'd0), fa_s};
    assign mb_s     = {(eb_s != 8'd0), fb_s};

    assign a_nan_s = (ea_s == 8'hFF) && (fa_s != 23'd0);
    assign b_nan_s = (eb_s == 8'hFF) && (fb_s != 23'd0);
    assign a_inf_s = (ea_s == 8'hFF) && (fa_s == 23'd0);
    assign b_inf_s = (eb_s == 8'hFF) && (fb_s == 23'd0);

    // ---------------------------------------------------------------------
    // Magnitude ordering: X is the operand with the larger magnitude
    // ---------------------------------------------------------------------
    logic        a_big_s;
    logic        sx_s;
    logic        sy_s;
    logic [7:0]  ex_s;
    logic [7:0]  ey_s;
    logic [23:0] mx_s;
    logic [23:0] my_s;
    logic [7:0]  diff_s;

    assign a_big_s = (ea_eff_s > eb_eff_s) ||
                     ((ea_eff_s == eb_eff_s) && (ma_s >= mb_s));

    // Swap operands so that X always carries the larger magnitude.
    always_comb begin
        if (a_big_s) begin
            sx_s = sa_s;
            sy_s = sb_s;
            ex_s = ea_eff_s;
            ey_s = eb_eff_s;
            mx_s = ma_s;
            my_s = mb_s;
        end else begin
            sx_s = sb_s;
            sy_s = sa_s;
            ex_s = eb_eff_s;
            ey_s = ea_eff_s;
            mx_s = mb_s;
            my_s = ma_s;
        end
    end

    assign diff_s = ex_s - ey_s;

    // ---------------------------------------------------------------------
    // Alignment: 24-bit significand plus guard, round and sticky = 27 bits
    // ---------------------------------------------------------------------
    logic [26:0] x_ext_s;
    logic [26:0] y_ext_s;
    logic [26:0] y_shr_s;
    logic        y_sticky_s;
    logic [26:0] y_al_s;

    assign x_ext_s = {mx_s, 3'b000};
    assign y_ext_s = {my_s, 3'b000};

    // Shift Y right by the exponent difference; any bit pushed out of the
    // 27-bit window is folded into the sticky position (bit 0).
    always_comb begin
        if (diff_s >= 8'd27) begin
            y_shr_s    = 27'd0;
            y_sticky_s = |my_s;
        end else begin
            y_shr_s    = y_ext_s >> diff_s[4:0];
            y_sticky_s = ((y_shr_s << diff_s[4:0]) != y_ext_s);
        end
    end

    assign y_al_s = y_shr_s | {26'd0, y_sticky_s};

    // ---------------------------------------------------------------------
    // Significand add / subtract. X >= Y in magnitude, so X - Y never wraps.
    // ---------------------------------------------------------------------
    logic        same_sign_s;
    logic [27:0] sum_s;

    assign same_sign_s = (sx_s == sy_s);
    assign sum_s = same_sign_s ? ({1'b0, x_ext_s} + {1'b0, y_al_s})
                               : ({1'b0, x_ext_s} - {1'b0, y_al_s});

    // ---------------------------------------------------------------------
    // Normalisation
    // ---------------------------------------------------------------------
    logic [4:0]  lz_s;
    logic [7:0]  max_sh_s;
    logic [7:0]  sh_s;
    logic [26:0] norm_s;
    logic [9:0]  e_norm_s;
    logic [9:0]  e_field_s;

    assign lz_s     = lzc27(sum_s[26:0]);
    assign max_sh_s = ex_s - 8'd1;

    // Carry out shifts right by one; otherwise shift left to bring the hidden
    // bit up, but never below exponent 1 (that is where subnormals live).
    always_comb begin
        sh_s = 8'd0;
        if (sum_s[27]) begin
            norm_s   = {sum_s[27:2], sum_s[1] | sum_s[0]};
            e_norm_s = {2'b00, ex_s} + 10'd1;
        end else begin
            if ({3'b000, lz_s} > max_sh_s) begin
                sh_s = max_sh_s;
            end else begin
                sh_s = {3'b000, lz_s};
            end
            norm_s   = sum_s[26:0] << sh_s;
            e_norm_s = {2'b00, ex_s} - {2'b00, sh_s};
        end
    end

    // Hidden bit still clear means the result is subnormal: exponent field 0.
    assign e_field_s = norm_s[26] ? e_norm_s : 10'd0;

    // ---------------------------------------------------------------------
    // Round to nearest, ties to even
    // ---------------------------------------------------------------------
    logic        rnd_s;
    logic [32:0] packed_s;
    logic        overflow_s;

    assign rnd_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);

    // Adding the increment to {exponent, fraction} lets a fraction carry
    // bump the exponent directly; this also promotes a subnormal that rounds
    // up to 0x800000 into the smallest normal.
    assign packed_s   = {e_field_s, norm_s[25:3]} + {32'd0, rnd_s};
    assign overflow_s = (packed_s[32:23] >= 10'd255);

    // ---------------------------------------------------------------------
    // Result selection, special cases first
    // ---------------------------------------------------------------------
    logic        zero_sign_s;
    logic [31:0] res_s;

    // A zero sum from opposite signs is an exact cancellation (+0); from equal
    // signs both operands were zero and their common sign is kept.
    assign zero_sign_s = same_sign_s ? sx_s : 1'b0;

    // Priority select between specials, zero, overflow and the rounded value.
    always_comb begin
        if (a_nan_s || b_nan_s) begin
            res_s = QNAN;
        end else if (a_inf_s && b_inf_s && (sa_s != sb_s)) begin
            res_s = QNAN;
        end else if (a_inf_s) begin
            res_s = {sa_s, 8'hFF, 23'd0};
        end else if (b_inf_s) begin
            res_s = {sb_s, 8'hFF, 23'd0};
        end else if (sum_s == 28'd0) begin
            res_s = {zero_sign_s, 31'd0};
        end else if (overflow_s) begin
            res_s = {sx_s, 8'hFF, 23'd0};
        end else begin
            res_s = {sx_s, packed_s[30:0]};
        end
    end

    // ---------------------------------------------------------------------
    // Output register
    // ---------------------------------------------------------------------
    logic [31:0] result_r;
    logic        out_valid_r;

    // Capture the result on valid input; reset wins and discards the operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_r    <= 32'd0;
            out_valid_r <= 1'b0;
        end else if (in_valid) begin
            result_r    <= res_s;
            out_valid_r <= 1'b1;
        end else begin
            result_r    <= result_r;
            out_valid_r <= 1'b0;
        end
    end

    assign Result    = result_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_fp32_add_sub.sv
// -----------------------------------------------------------------------------
// tb_fp32_add_sub
//
// Self-checking bench for fp32_add_sub. The driver applies directed vectors on
// the falling edge and pushes the expected result into a queue whenever the
// operation will be accepted. A monitor samples after every rising edge and
// checks out_valid, the new Result (popped from the queue), held values while
// idle, and the cleared state during reset.
// -----------------------------------------------------------------------------
module tb_fp32_add_sub;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] NumberA;
    logic [31:0] NumberB;
    logic        A_S;
    logic [31:0] Result;
    logic        out_valid;

    fp32_add_sub dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .NumberA   (NumberA),
        .NumberB   (NumberB),
        .A_S       (A_S),
        .Result    (Result),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] last_result;
    logic        mon_v;
    logic        mon_r;
    logic [31:0] mon_exp;
    string       mon_tag;

    // Single comparison point: counts and reports.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one operation on the falling edge; queue its expectation if taken.
    task automatic drive_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic as, input logic [31:0] exp);
        @(negedge clk);
        NumberA  = a;
        NumberB  = b;
        A_S      = as;
        in_valid = 1'b1;
        if (rst_n) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
    endtask

    // Idle cycles with scrambled operands to prove Result ignores them.
    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            NumberA  = $urandom;
            NumberB  = $urandom;
            A_S      = 1'($urandom_range(0, 1));
        end
    endtask

    // Monitor: evaluate what the edge should have done, then check #1 later.
    always @(posedge clk) begin
        mon_v = rst_n && in_valid;
        mon_r = !rst_n;
        #1;
        if (mon_r) begin
            last_result = 32'd0;
            check_eq("reset_result", Result, 32'd0);
            check_eq("reset_valid", {31'd0, out_valid}, 32'd0);
        end else if (mon_v) begin
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
            end else begin
                mon_exp = ~last_result;
                mon_tag = "unexpected_op";
            end
            check_eq({mon_tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            check_eq(mon_tag, Result, mon_exp);
            last_result = mon_exp;
        end else begin
            check_eq("idle_valid", {31'd0, out_valid}, 32'd0);
            check_eq("idle_hold", Result, last_result);
        end
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        last_result = 32'd0;
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        NumberA     = 32'h3F80_0000;
        NumberB     = 32'h3F80_0000;
        A_S         = 1'b0;

        // Reset held while in_valid is high: nothing may come out.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        drive_idle(1);

        // Back-to-back directed vectors.
        drive_op("sub_sub_carry",   32'h0055_5551, 32'h0055_5555, 1'b0, 32'h00AA_AAA6);
        drive_op("sub_mixed",       32'h007F_FFFF, 32'h802A_55AA, 1'b0, 32'h0055_AA55);
        drive_op("sub_mixed_swap",  32'h002A_55AA, 32'h807F_FFFF, 1'b0, 32'h8055_AA55);
        drive_op("sub_neg_sub",     32'h805D_DDDD, 32'h801D_DDDD, 1'b1, 32'h8040_0000);
        drive_op("one_plus_one",    32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000);
        drive_op("one_minus_one",   32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000);
        drive_op("tie_even_down",   32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000);
        drive_op("tie_odd_up",      32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002);
        drive_op("above_half_up",   32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001);
        drive_op("max_overflow",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000);
        drive_op("inf_minus_inf",   32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000);
        drive_op("neg_inf_pos_inf", 32'hFF80_0000, 32'h7F80_0000, 1'b0, 32'h7FC0_0000);
        drive_op("inf_minus_ninf",  32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7F80_0000);
        drive_op("inf_plus_one",    32'h3F80_0000, 32'hFF80_0000, 1'b0, 32'hFF80_0000);
        drive_op("nan_operand",     32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000);
        drive_op("nan_vs_inf",      32'h7F80_0000, 32'hFFC1_2345, 1'b1, 32'h7FC0_0000);
        drive_op("neg0_plus_neg0",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000);
        drive_op("neg0_minus_pos0", 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000);
        drive_op("pos0_plus_neg0",  32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000);
        drive_op("x_plus_zero",     32'h4049_0FDB, 32'h0000_0000, 1'b0, 32'h4049_0FDB);
        drive_op("zero_minus_x",    32'h0000_0000, 32'h4049_0FDB, 1'b1, 32'hC049_0FDB);
        drive_op("one_plus_two",    32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
        drive_op("onehalf_m_half",  32'h3FC0_0000, 32'h3F00_0000, 1'b1, 32'h3F80_0000);
        drive_op("near_cancel",     32'h3F80_0001, 32'h3F80_0000, 1'b1, 32'h3400_0000);
        drive_op("normal_to_sub",   32'h0080_0000, 32'h0000_0001, 1'b1, 32'h007F_FFFF);
        drive_op("tiny_absorbed",   32'h3F80_0000, 32'h0000_0001, 1'b0, 32'h3F80_0000);

        // Deassert in_valid: Result must hold the last value.
        drive_idle(3);

        // Reset asserted with an operation pending: operation is discarded.
        @(negedge clk);
        rst_n = 1'b0;
        drive_op("during_reset", 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        drive_op("after_reset", 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000);
        drive_idle(3);

        @(negedge clk);
        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
